// File: rtl/pcs_scr_pkg.sv
// Shared constants, types and the bit-serial step function for the 64B/66B
// self-synchronous scrambler (G(x) = 1 + x^39 + x^58).
package pcs_scr_pkg;

  localparam int unsigned LFSR_W = 58;
  localparam int unsigned TAP_A  = 39;
  localparam int unsigned TAP_B  = 58;
  localparam int unsigned MAX_W  = 128;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic {
    SCRAMBLE   = 1'b0,
    DESCRAMBLE = 1'b1
  } scr_mode_e;

  typedef struct packed {
    logic [LFSR_W-1:0] state;
    logic [MAX_W-1:0]  data;
  } scr_res_t;

  // state[k] holds history bit S[k-58]: state[0] is the oldest, state[57] the newest.
  function automatic scr_res_t scr_step(input logic [LFSR_W-1:0] state,
                                        input logic [MAX_W-1:0]  data,
                                        input scr_mode_e         mode,
                                        input int unsigned       width);
    scr_res_t          res;
    logic [LFSR_W-1:0] st;
    logic              o;
    logic              fb;
    st       = state;
    res.data = '0;
    o        = 1'b0;
    fb       = 1'b0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        o           = data[i] ^ st[LFSR_W-TAP_A] ^ st[LFSR_W-TAP_B];
        fb          = (mode == DESCRAMBLE) ? data[i] : o;
        res.data[i] = o;
        st          = {fb, st[LFSR_W-1:1]};
      end
    end
    res.state = st;
    return res;
  endfunction

endpackage

// File: rtl/pcs_skid_buf.sv
// Generic two-entry valid/ready buffer: output register plus one skid entry,
// with a registered ready that drops once the skid entry is occupied.
module pcs_skid_buf #(
  parameter int unsigned WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    push         = in_valid && in_ready_q;
    pop          = out_valid_q && out_ready;
    if (!out_valid_q || pop) begin
      // Skid entry always drains first so ordering is preserved.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/pcs_scrambler_pipe.sv
// 64B/66B self-synchronous scrambler/descrambler with bypass, seed reload and
// skid-buffered output. Optional test_mode port under PCS_SCR_TEST_PATTERN_EN.
module pcs_scrambler_pipe
  import pcs_scr_pkg::*;
#(
  parameter int unsigned       DATA_W  = 64,
  parameter int unsigned       MODE    = 0,
  parameter int unsigned       REVERSE = 0,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_hdr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bypass,
  input  logic              seed_load,
`ifdef PCS_SCR_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_hdr,
  output logic [DATA_W-1:0] out_data
);

  localparam scr_mode_e   MODE_E = (MODE != 0) ? DESCRAMBLE : SCRAMBLE;
  localparam int unsigned BUF_W  = DATA_W + 2;

  logic [LFSR_W-1:0] state_q, state_d;
  logic [1:0]        hdr_eff;
  logic [DATA_W-1:0] data_eff;
  logic              byp_eff;
  logic [MAX_W-1:0]  wire_d;
  scr_res_t          res;
  logic [DATA_W-1:0] scr_data;
  logic [DATA_W-1:0] proc_data;
  logic [BUF_W-1:0]  buf_in, buf_out;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    hdr_eff  = in_hdr;
    data_eff = in_data;
    byp_eff  = bypass;
`ifdef PCS_SCR_TEST_PATTERN_EN
    if (test_mode && (MODE_E == SCRAMBLE)) begin
      hdr_eff  = 2'b01;
      data_eff = '0;
      byp_eff  = 1'b0;
    end
`endif
    // Reorder into wire order so the step function always walks bit 0 first.
    wire_d = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      wire_d[i] = (REVERSE != 0) ? data_eff[DATA_W-1-i] : data_eff[i];
    end
    res      = scr_step(state_q, wire_d, MODE_E, DATA_W);
    scr_data = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (REVERSE != 0) scr_data[DATA_W-1-i] = res.data[i];
      else              scr_data[i]          = res.data[i];
    end
    proc_data = byp_eff ? data_eff : scr_data;
    state_d   = state_q;
    if (accept && !byp_eff) state_d = res.state;
    if (seed_load)          state_d = SEED;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  generate
    if (DATA_W < MAX_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^res.data[MAX_W-1:DATA_W];
    end
  endgenerate

  assign buf_in = {hdr_eff, proc_data};

  pcs_skid_buf #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_hdr  = buf_out[BUF_W-1:DATA_W];
  assign out_data = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_pcs_scrambler_pipe.sv
// Bench for pcs_scrambler_pipe: scrambler instance looped into a descrambler,
// checked against a queue-based history model of the scrambling rules.
module tb_pcs_scrambler_pipe;

  localparam logic [57:0] SEED_A = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] K1     = 64'h03FF_FF80_0000_0000;
  localparam logic [63:0] K2     = 64'hFFEF_FFFF_FFFF_C000;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, a_in_ready, bypass, seed_load;
  logic [1:0]  in_hdr, a_out_hdr, b_out_hdr;
  logic [63:0] in_data, a_out_data, b_out_data;
  logic        a_out_valid, a_out_ready, tb_ready;
  logic        b_in_valid, b_in_ready, b_out_valid;
`ifdef PCS_SCR_TEST_PATTERN_EN
  logic        test_mode;
`endif

  always #5 CLK = ~CLK;

  assign a_out_ready = tb_ready & b_in_ready;
  assign b_in_valid  = a_out_valid & tb_ready;

  pcs_scrambler_pipe #(.DATA_W(64), .MODE(0), .REVERSE(0), .SEED(SEED_A)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_hdr(in_hdr), .in_data(in_data), .bypass(bypass), .seed_load(seed_load),
`ifdef PCS_SCR_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_hdr(a_out_hdr), .out_data(a_out_data)
  );

  pcs_scrambler_pipe #(.DATA_W(64), .MODE(1), .REVERSE(0), .SEED(58'h0)) u_rx (
    .CLK(CLK), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_hdr(a_out_hdr), .in_data(a_out_data), .bypass(1'b0), .seed_load(1'b0),
`ifdef PCS_SCR_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .out_valid(b_out_valid), .out_ready(1'b1), .out_hdr(b_out_hdr), .out_data(b_out_data)
  );

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] data;
    bit          hk;
    logic [63:0] k;
  } exp_t;

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] data;
    bit          byp;
    bit          sl;
    bit          hk;
    logic [63:0] k;
  } vec_t;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];
  bit          hist[$];
  vec_t        tbl[14];
  int          vectors = 0;
  int          miscompares = 0;
  int          b_beats = 0;
  bit          lb_check = 1'b0;
  bit          rand_ready = 1'b0;
  bit          accepted = 1'b0;
  bit          cur_has_k = 1'b0;
  logic [63:0] cur_k = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    logic [57:0] s;
    s = SEED_A;
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(s[i]);
  endfunction

  // Wire-order stream model: each output bit taps the bit 39 and 58 places back.
  function automatic logic [63:0] model_beat(input logic [63:0] d, input bit byp);
    logic [63:0] o;
    if (byp) return d;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(o[i]);
      void'(hist.pop_front());
    end
    return o;
  endfunction

  task automatic tick();
    exp_t        e;
    logic [63:0] s;
    logic [1:0]  h;
    logic [63:0] d;
    bit          b;
    if (rand_ready) tb_ready = ($urandom_range(0, 3) != 0);
    @(negedge CLK);
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stale_beat: got %h, expected no beat", a_out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", a_out_data, e.data);
        check("out_hdr", 64'(a_out_hdr), 64'(e.hdr));
        if (e.hk) check("out_data_const", a_out_data, e.k);
      end
    end
    if (lb_check && b_out_valid) begin
      if (src_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL loopback_extra: got %h, expected no beat", b_out_data);
      end else begin
        s = src_q.pop_front();
        if (b_beats > 0) check("loopback", b_out_data, s);
        b_beats++;
      end
    end
    if (in_valid && a_in_ready) begin
      h = in_hdr;
      d = in_data;
      b = bypass;
`ifdef PCS_SCR_TEST_PATTERN_EN
      if (test_mode) begin
        h = 2'b01;
        d = '0;
        b = 1'b0;
      end
`endif
      e.hdr  = h;
      e.data = model_beat(d, b);
      e.hk   = cur_has_k;
      e.k    = cur_k;
      exp_q.push_back(e);
      if (lb_check) src_q.push_back(in_data);
      accepted = 1'b1;
    end
    if (seed_load) model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] d, input bit byp,
                      input bit sl, input bit hk, input logic [63:0] k);
    in_valid  = 1'b1;
    in_hdr    = h;
    in_data   = d;
    bypass    = byp;
    seed_load = sl;
    cur_has_k = hk;
    cur_k     = k;
    accepted  = 1'b0;
    for (int n = 0; n < 64 && !accepted; n++) tick();
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept, expected accept within 64 cycles");
    end
    in_valid  = 1'b0;
    bypass    = 1'b0;
    seed_load = 1'b0;
    cur_has_k = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bypass    = 1'b0;
    seed_load = 1'b0;
`ifdef PCS_SCR_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    exp_q.delete();
    src_q.delete();
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #3;
    rst_n = 1'b1;
    check("rst_out_data", a_out_data, 64'd0);
    check("rst_out_hdr", 64'(a_out_hdr), 64'd0);
    check("rst_release_ready_low", 64'(a_in_ready), 64'd0);
    @(posedge CLK);
    #1;
    check("rst_release_ready_high", 64'(a_in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_ready = 1'b1;
    in_hdr   = '0;
    in_data  = '0;
    // Zero stream from reset: bypass on beats 3-4, seed reload with beat 11.
    tbl[0]  = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b1, K1};
    tbl[1]  = '{2'b10, 64'h0, 1'b0, 1'b0, 1'b1, K2};
    tbl[2]  = '{2'b01, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0};
    tbl[3]  = '{2'b10, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0};
    tbl[4]  = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[5]  = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[6]  = '{2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[7]  = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[8]  = '{2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[9]  = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[10] = '{2'b01, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[11] = '{2'b01, 64'h0, 1'b0, 1'b0, 1'b1, K1};
    tbl[12] = '{2'b10, 64'h0, 1'b0, 1'b0, 1'b1, K2};
    tbl[13] = '{2'b10, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567};

    // Single zero beat: value and one-cycle latency.
    do_reset();
    check("idle_out_valid", 64'(a_out_valid), 64'd0);
    send(2'b01, 64'h0, 1'b0, 1'b0, 1'b1, K1);
    check("latency_valid", 64'(a_out_valid), 64'd1);
    tick();
    check("single_beat_only", 64'(a_out_valid), 64'd0);

    // Table-driven zero stream with bypass and seed reload.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].hdr, tbl[i].data, tbl[i].byp, tbl[i].sl, tbl[i].hk, tbl[i].k);
    end
    repeat (3) tick();
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: five stalled cycles with continuous in_valid.
    in_valid = 1'b1;
    in_hdr   = 2'b01;
    in_data  = {$urandom, $urandom};
    for (int c = 0; c < 12; c++) begin
      tb_ready = (c >= 5);
      accepted = 1'b0;
      tick();
      if (c == 0) check("bp_ready_one_entry", 64'(a_in_ready), 64'd1);
      if (c == 1) check("bp_ready_fall", 64'(a_in_ready), 64'd0);
      if (c == 4) check("bp_ready_held_low", 64'(a_in_ready), 64'd0);
      if (c >= 2 && c <= 4) begin
        check("bp_hold_valid", 64'(a_out_valid), 64'd1);
        check("bp_hold_data", a_out_data, exp_q[0].data);
      end
      if (accepted) in_data = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Loopback into the descrambler with random backpressure.
    do_reset();
    lb_check   = 1'b1;
    b_beats    = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom},
           1'b0, 1'b0, 1'b0, 64'h0);
    end
    rand_ready = 1'b0;
    tb_ready   = 1'b1;
    repeat (8) tick();
    check("loopback_count", 64'(b_beats), 64'd1000);
    check("loopback_drained", 64'(src_q.size()), 64'd0);
    lb_check = 1'b0;

    // Reset with both buffer entries occupied.
    tb_ready = 1'b0;
    send(2'b01, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 64'h0);
    send(2'b10, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 1'b0, 64'h0);
    check("full_in_ready", 64'(a_in_ready), 64'd0);
    check("full_out_valid", 64'(a_out_valid), 64'd1);
    #2;
    do_reset();
    tb_ready = 1'b1;
    repeat (3) tick();
    send(2'b01, 64'h0, 1'b0, 1'b0, 1'b1, K1);
    repeat (2) tick();
    check("post_reset_drained", 64'(exp_q.size()), 64'd0);

`ifdef PCS_SCR_TEST_PATTERN_EN
    do_reset();
    test_mode = 1'b1;
    send(2'b10, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1, K1);
    send(2'b10, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, K2);
    test_mode = 1'b0;
    repeat (2) tick();
    check("test_mode_drained", 64'(exp_q.size()), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
